// File: rtl/cra_seq.sv
// Microsequencer address logic: registered CRADR, dispatch/skip merging and a return-address stack.
// Define CRA_DIAG_LOAD_EN to add the diagLoad/diagAdr direct address-load path.
module cra_seq #(
  parameter int STACK_DEPTH = 16
) (
  input  logic        eboxClk,
  input  logic        eboxReset,
  input  logic        crStall,
  input  logic [0:10] CRAM_J,
  input  logic        CRAM_CALL,
  input  logic [0:4]  CRAM_DISP,
  input  logic        skipTrue,
  input  logic [0:3]  dispIn,
  input  logic [0:10] DRAM_J,
`ifdef CRA_DIAG_LOAD_EN
  input  logic        diagLoad,
  input  logic [0:10] diagAdr,
`endif
  output logic [0:10] CRADR,
  output logic [5:0]  stackDepth,
  output logic        stackOvf,
  output logic        stackUnf
);

  localparam int         AW   = $clog2(STACK_DEPTH);
  localparam logic [5:0] FULL = 6'(STACK_DEPTH);

  typedef enum logic [1:0] {
    DISP_NONE,
    DISP_RET,
    DISP_DRAM,
    DISP_MULTI
  } disp_e;

  disp_e       disp_sel;
  logic [0:10] cradr_q, cradr_d;
  logic [5:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [0:10] stack_q [STACK_DEPTH];

  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;
  logic          push_we;
  logic [5:0]    popped_depth;
  logic [0:10]   tos;
  logic [0:10]   base;
  logic          diag_ld;
  logic [0:10]   diag_adr;

`ifdef CRA_DIAG_LOAD_EN
  assign diag_ld  = diagLoad;
  assign diag_adr = diagAdr;
`else
  assign diag_ld  = 1'b0;
  assign diag_adr = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    disp_sel = DISP_NONE;
    if (CRAM_DISP[0])                disp_sel = DISP_MULTI;
    else if (CRAM_DISP == 5'b00001)  disp_sel = DISP_RET;
    else if (CRAM_DISP == 5'b00010)  disp_sel = DISP_DRAM;
  end

  // An empty stack reads as zero so an underflowing RETURN jumps straight to CRAM_J.
  always_comb begin
    top_idx = AW'(depth_q - 6'd1);
    tos     = (depth_q != 6'd0) ? stack_q[top_idx] : '0;
  end

  always_comb begin
    base = CRAM_J;
    case (disp_sel)
      DISP_RET:   base = tos | CRAM_J;
      DISP_DRAM:  base = DRAM_J;
      DISP_MULTI: base[7:10] = CRAM_J[7:10] | dispIn;
      default:    base = CRAM_J;
    endcase
    if (disp_sel != DISP_RET) base[10] = base[10] | skipTrue;
  end

  // Pop is resolved before push, so CALL+RETURN replaces the top entry in place.
  always_comb begin
    cradr_d      = cradr_q;
    depth_d      = depth_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    push_we      = 1'b0;
    push_idx     = '0;
    popped_depth = depth_q;
    if (diag_ld) begin
      cradr_d = diag_adr;
    end else if (!crStall) begin
      cradr_d = base;
      if (disp_sel == DISP_RET) begin
        if (depth_q == 6'd0) unf_d = 1'b1;
        else                 popped_depth = depth_q - 6'd1;
      end
      depth_d = popped_depth;
      if (CRAM_CALL) begin
        if (popped_depth == FULL) begin
          ovf_d = 1'b1;
        end else begin
          push_we  = 1'b1;
          push_idx = AW'(popped_depth);
          depth_d  = popped_depth + 6'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      cradr_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cradr_q <= cradr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the stack array is deliberately not reset; entries above depth are never read.
  always_ff @(posedge eboxClk) begin
    if (push_we && !eboxReset) stack_q[push_idx] <= cradr_q;
  end

  assign CRADR      = cradr_q;
  assign stackDepth = depth_q;
  assign stackOvf   = ovf_q;
  assign stackUnf   = unf_q;

endmodule

// File: tb/tb_cra_seq.sv
// Directed bench for cra_seq: a vector table for dispatch/stack sequences plus hand-written
// reset, stall, overflow and underflow sequences.
module tb_cra_seq;
  localparam int DEPTH = 16;

  logic        eboxClk = 1'b0;
  logic        eboxReset;
  logic        crStall;
  logic [0:10] CRAM_J;
  logic        CRAM_CALL;
  logic [0:4]  CRAM_DISP;
  logic        skipTrue;
  logic [0:3]  dispIn;
  logic [0:10] DRAM_J;
  logic [0:10] CRADR;
  logic [5:0]  stackDepth;
  logic        stackOvf;
  logic        stackUnf;
`ifdef CRA_DIAG_LOAD_EN
  logic        diagLoad;
  logic [0:10] diagAdr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cra_seq #(.STACK_DEPTH(DEPTH)) dut (
    .eboxClk   (eboxClk),
    .eboxReset (eboxReset),
    .crStall   (crStall),
    .CRAM_J    (CRAM_J),
    .CRAM_CALL (CRAM_CALL),
    .CRAM_DISP (CRAM_DISP),
    .skipTrue  (skipTrue),
    .dispIn    (dispIn),
    .DRAM_J    (DRAM_J),
`ifdef CRA_DIAG_LOAD_EN
    .diagLoad  (diagLoad),
    .diagAdr   (diagAdr),
`endif
    .CRADR     (CRADR),
    .stackDepth(stackDepth),
    .stackOvf  (stackOvf),
    .stackUnf  (stackUnf)
  );

  always #5 eboxClk = ~eboxClk;

  typedef struct {
    logic        call;
    logic [4:0]  disp;
    logic [10:0] j;
    logic        skip;
    logic [3:0]  din;
    logic [10:0] dj;
    logic [10:0] e_adr;
    logic [5:0]  e_dep;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [10:0] adr, input logic [5:0] dep,
                             input logic ovf, input logic unf);
    check({name, " CRADR"}, 32'(CRADR), 32'(adr));
    check({name, " depth"}, 32'(stackDepth), 32'(dep));
    check({name, " ovf"},   32'(stackOvf), 32'(ovf));
    check({name, " unf"},   32'(stackUnf), 32'(unf));
  endtask

  task automatic drive(input logic call, input logic [4:0] disp, input logic [10:0] j,
                       input logic skip, input logic [3:0] din, input logic [10:0] dj);
    CRAM_CALL = call;
    CRAM_DISP = disp;
    CRAM_J    = j;
    skipTrue  = skip;
    dispIn    = din;
    DRAM_J    = dj;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge eboxClk);
    #1;
  endtask

  task automatic do_reset();
    eboxReset = 1'b1;
    tick();
    eboxReset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //             call disp      j       skip din   dram     exp      depth
    vecs[0]  = '{1'b0, 5'b10000, 11'h200, 1'b1, 4'h5, 11'h000, 11'h205, 6'd0};
    vecs[1]  = '{1'b0, 5'b00010, 11'h7FF, 1'b1, 4'hF, 11'h4A0, 11'h4A1, 6'd0};
    vecs[2]  = '{1'b0, 5'b00000, 11'h040, 1'b0, 4'h0, 11'h000, 11'h040, 6'd0};
    vecs[3]  = '{1'b1, 5'b00000, 11'h300, 1'b0, 4'h0, 11'h000, 11'h300, 6'd1};
    vecs[4]  = '{1'b0, 5'b00001, 11'h001, 1'b0, 4'h0, 11'h000, 11'h041, 6'd0};
    vecs[5]  = '{1'b0, 5'b11111, 11'h00F, 1'b0, 4'h3, 11'h000, 11'h00F, 6'd0};
    vecs[6]  = '{1'b0, 5'b00011, 11'h154, 1'b0, 4'hF, 11'h7FF, 11'h154, 6'd0};
    vecs[7]  = '{1'b1, 5'b00000, 11'h060, 1'b0, 4'h0, 11'h000, 11'h060, 6'd1};
    vecs[8]  = '{1'b0, 5'b00001, 11'h200, 1'b1, 4'h0, 11'h000, 11'h354, 6'd0};
    vecs[9]  = '{1'b0, 5'b00000, 11'h010, 1'b0, 4'h0, 11'h000, 11'h010, 6'd0};
    vecs[10] = '{1'b1, 5'b00000, 11'h050, 1'b0, 4'h0, 11'h000, 11'h050, 6'd1};
    vecs[11] = '{1'b1, 5'b00000, 11'h060, 1'b0, 4'h0, 11'h000, 11'h060, 6'd2};
    vecs[12] = '{1'b1, 5'b00001, 11'h003, 1'b0, 4'h0, 11'h000, 11'h053, 6'd2};
    vecs[13] = '{1'b0, 5'b00001, 11'h000, 1'b0, 4'h0, 11'h000, 11'h060, 6'd1};
    vecs[14] = '{1'b0, 5'b00001, 11'h100, 1'b0, 4'h0, 11'h000, 11'h110, 6'd0};
    vecs[15] = '{1'b0, 5'b10110, 11'h400, 1'b1, 4'h8, 11'h000, 11'h409, 6'd0};

    crStall   = 1'b0;
`ifdef CRA_DIAG_LOAD_EN
    diagLoad  = 1'b0;
    diagAdr   = '0;
`endif
    drive(1'b0, 5'b00000, 11'h123, 1'b0, 4'h0, 11'h000);

    // Reset holds CRADR at 0 despite a live jump; the jump appears one clock after release.
    eboxReset = 1'b1;
    #1;
    tick();
    tick();
    check_state("reset", 11'h000, 6'd0, 1'b0, 1'b0);
    eboxReset = 1'b0;
    tick();
    check_state("jump after reset", 11'h123, 6'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].call, vecs[i].disp, vecs[i].j, vecs[i].skip, vecs[i].din, vecs[i].dj);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].e_adr, vecs[i].e_dep, 1'b0, 1'b0);
    end

    // Stall: decode inputs, including CALL and RETURN, must be ignored.
    drive(1'b1, 5'b00000, 11'h222, 1'b0, 4'h0, 11'h000);
    tick();
    check_state("call before stall", 11'h222, 6'd1, 1'b0, 1'b0);
    crStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 1) ? 5'b00001 : 5'b10000, 11'(11'h111 + i), 1'b1, 4'hF, 11'h000);
      tick();
      check_state($sformatf("stall%0d", i), 11'h222, 6'd1, 1'b0, 1'b0);
    end
`ifdef CRA_DIAG_LOAD_EN
    diagLoad = 1'b1;
    diagAdr  = 11'h7FF;
    tick();
    check_state("diag load in stall", 11'h7FF, 6'd1, 1'b0, 1'b0);
    diagLoad = 1'b0;
`endif
    crStall = 1'b0;
    drive(1'b0, 5'b00000, 11'h333, 1'b0, 4'h0, 11'h000);
    tick();
    check_state("after stall", 11'h333, 6'd1, 1'b0, 1'b0);

    // Asynchronous reset in mid-cycle during a pending CALL.
    drive(1'b1, 5'b00000, 11'h444, 1'b0, 4'h0, 11'h000);
    #2;
    eboxReset = 1'b1;
    #1;
    check_state("async reset", 11'h000, 6'd0, 1'b0, 1'b0);
    tick();
    eboxReset = 1'b0;
    check_state("held in reset", 11'h000, 6'd0, 1'b0, 1'b0);

    // Underflow: RETURN on an empty stack jumps to CRAM_J and sets a sticky flag.
    drive(1'b0, 5'b00001, 11'h007, 1'b0, 4'h0, 11'h000);
    tick();
    check_state("underflow", 11'h007, 6'd0, 1'b0, 1'b1);
    drive(1'b0, 5'b00000, 11'h020, 1'b0, 4'h0, 11'h000);
    tick();
    check_state("unf sticky", 11'h020, 6'd0, 1'b0, 1'b1);

    // Overflow: the 17th CALL still jumps but its push is discarded.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, 5'b00000, 11'(11'h100 + k), 1'b0, 4'h0, 11'h000);
      tick();
      if (k == 16) check_state("full stack", 11'h110, 6'd16, 1'b0, 1'b0);
    end
    check_state("overflow", 11'h111, 6'd16, 1'b1, 1'b0);
    drive(1'b0, 5'b00001, 11'h000, 1'b0, 4'h0, 11'h000);
    tick();
    check_state("pop after overflow", 11'h10F, 6'd15, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cra_seq.md
CRA_SEQ -- requirements
Module: cra_seq

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, meaning the number of subroutine-return entries, a power of two between 4 and 32.
REQ-002 SHALL have port eboxClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port eboxReset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port crStall, input, 1 bit: when 1, all state is held.
REQ-005 SHALL have port CRAM_J, input, 11 bits [0:10]: jump field of the current microword.
REQ-006 SHALL have port CRAM_CALL, input, 1 bit: push the return address.
REQ-007 SHALL have port CRAM_DISP, input, 5 bits [0:4]: dispatch select.
REQ-008 SHALL have port skipTrue, input, 1 bit: the evaluated skip condition.
REQ-009 SHALL have port dispIn, input, 4 bits [0:3]: the multiway dispatch value.
REQ-010 SHALL have port DRAM_J, input, 11 bits [0:10]: the instruction dispatch target.
REQ-011 SHALL have port CRADR, output, 11 bits [0:10]: registered control-store address, which feeds the control-store read.
REQ-012 SHALL have port stackDepth, output, 6 bits: the current number of stack entries.
REQ-013 SHALL have ports stackOvf and stackUnf, output, 1 bit each: sticky error flags.

Function
REQ-014 SHALL register CRADR; the address computed from the current microword fields appears on CRADR one eboxClk after those fields, giving one-cycle latency.
REQ-015 SHALL decode CRAM_DISP as follows: 00000 = none; 00001 = RETURN; 00010 = DRAM dispatch; 1xxxx = multiway dispatch; all other codes = none.
REQ-016 SHALL compute the base address with this priority: RETURN gives top-of-stack OR CRAM_J; DRAM dispatch gives DRAM_J; otherwise the base is CRAM_J.
REQ-017 SHALL, for multiway dispatch, OR dispIn into base bits [7:10].
REQ-018 SHALL OR skipTrue into bit 10 of the next address for every code except RETURN.
REQ-019 SHALL perform all OR operations bitwise with no carry, keeping the address at 11 bits.
REQ-020 SHALL, on CRAM_CALL=1, push the current CRADR value and increment stackDepth.
REQ-021 SHALL, on RETURN, pop the stack and decrement stackDepth.
REQ-022 SHALL, on CALL and RETURN in the same cycle, pop first and then push: the top entry is replaced by the current CRADR and depth is unchanged.
REQ-023 SHALL, on a push while depth equals STACK_DEPTH, discard the push, leave the stack unchanged and set stackOvf.
REQ-024 SHALL, on RETURN while depth is 0, use a top-of-stack value of 0 (next address is CRAM_J), keep depth at 0 and set stackUnf.
REQ-025 SHALL, while crStall=1, hold CRADR, the stack, depth and both flags, and ignore all decode inputs.
REQ-026 SHALL clear stackOvf and stackUnf only by reset.

Reset
REQ-027 SHALL, on eboxReset=1, immediately and asynchronously set CRADR=0, stackDepth=0, stackOvf=0 and stackUnf=0.
REQ-028 SHALL leave stack entry contents undefined after reset; they are never read while depth is 0.
REQ-029 SHALL abort any push or pop in progress when reset is asserted mid-operation, with no partial update.
REQ-030 SHALL resume normal operation on the first eboxClk edge after eboxReset deasserts.

Configuration
REQ-031 SHALL, when macro CRA_DIAG_LOAD_EN is defined, add input diagLoad (1 bit) and input diagAdr (11 bits).
REQ-032 SHALL, with CRA_DIAG_LOAD_EN defined and diagLoad=1, load CRADR=diagAdr on the next edge, overriding crStall and all dispatch, with the stack, depth and flags unchanged.
REQ-033 SHALL, when CRA_DIAG_LOAD_EN is undefined, omit the diagLoad and diagAdr ports and remove the load path; behaviour is otherwise identical.

Verification
REQ-034 SHALL cover reset and jump: assert eboxReset, then CRAM_J=0x123 with DISP=0 and skipTrue=0 -> CRADR=0 during reset, then 0x123 one clock after release.
REQ-035 SHALL cover skip plus multiway: CRAM_J=0x200, DISP=10000, dispIn=0x5, skipTrue=1 -> CRADR=0x205.
REQ-036 SHALL cover call and return: with CRADR=0x040, CALL=1 and J=0x300 -> CRADR=0x300 and depth=1; then DISP=00001 and J=0x001 -> CRADR=0x041 and depth=0.
REQ-037 SHALL cover overflow and underflow: 17 consecutive CALLs with STACK_DEPTH=16 -> depth=16 and stackOvf=1; after reset, RETURN with J=0x7 -> CRADR=0x007 and stackUnf=1.
REQ-038 SHALL cover stall: crStall=1 for 3 cycles while J changes -> CRADR and depth unchanged; with CRA_DIAG_LOAD_EN defined, diagLoad=1 and diagAdr=0x7FF during the stall -> CRADR=0x7FF.
REQ-039 SHALL cover simultaneous CALL and RETURN at depth 2 with top=0x050 and CRADR=0x060 -> next address is 0x050 OR J, depth=2, and the new top is 0x060.
